// File: rtl/regfile_pkg.sv
// Shared definitions for the banked register file: bank encodings,
// sweep FSM state encoding and default geometry.
package regfile_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_ADDR_W    = 5;
    localparam int DEF_NUM_BANKS = 2;
    localparam int DEF_NUM_RD    = 2;
    localparam int DEF_BANK_W    = 1;

    // Bank 0 holds integer registers, bank 1 and above hold float.
    localparam int BANK_INT = 0;
    localparam int BANK_FP  = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_bank.sv
// One DEPTH x DATA_W register bank: a clear port, two write ports
// (pair halves) and NUM_RD combinational read ports.
//
// Ports:
//   clk            rising-edge clock
//   clrEn/clrAddr  sweep clear; overrides both write ports
//   loEn/loAddr/loData  first write port (single or low half)
//   hiEn/hiAddr/hiData  second write port (odd half of a pair)
//   rdAddr         packed per-port read index
//   rdData         packed per-port raw storage contents
module regfile_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     clrEn,
    input  logic [ADDR_W-1:0]        clrAddr,
    input  logic                     loEn,
    input  logic [ADDR_W-1:0]        loAddr,
    input  logic [DATA_W-1:0]        loData,
    input  logic                     hiEn,
    input  logic [ADDR_W-1:0]        hiAddr,
    input  logic [DATA_W-1:0]        hiData,
    input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
    output logic [NUM_RD*DATA_W-1:0] rdData
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Storage is deliberately unreset; the sweep clears it instead.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clrEn) begin
            mem[clrAddr] <= '0;
        end else begin
            if (loEn) begin
                mem[loAddr] <= loData;
            end
            if (hiEn) begin
                mem[hiAddr] <= hiData;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        assign rdData[p*DATA_W +: DATA_W] = mem[rdAddr[p*ADDR_W +: ADDR_W]];
    end

endmodule

// File: rtl/banked_register_file.sv
// Multi-bank register file (bank 0 integer, others float) with
// write-first bypass, even/odd pair writes and a self-timed clear sweep.
//
// Ports:
//   clk, rst           clock, async active-high reset
//   rd_bank/rd_addr    packed per-port read selects
//   rd_data            packed per-port read data
//   wr_en/wr_bank/wr_addr/wr_data   write port
//   wr_pair/wr_data_hi also write the odd neighbour (float banks only)
//   clr_req            request a new clear sweep
//   busy               sweep in progress
//   pair_err           one-cycle pulse for a rejected pair write
module banked_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int NUM_RD    = DEF_NUM_RD,
    parameter int BANK_W    = DEF_BANK_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*BANK_W-1:0] rd_bank,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [BANK_W-1:0]        wr_bank,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_pair,
    input  logic [DATA_W-1:0]        wr_data_hi,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     pair_err
);

    if ((2 ** BANK_W) < NUM_BANKS) begin : g_bad_bank_w
        $error("BANK_W too narrow for NUM_BANKS");
    end

    rf_state_e         state;
    logic [ADDR_W-1:0] cnt;

    logic              isIdle;
    logic              bankOk;
    logic              isZeroReg;
    logic              pairLegal;
    logic              loAcc;
    logic              hiAcc;
    logic              pairBad;
    logic [ADDR_W-1:0] hiAddr;

    assign isIdle    = (state == IDLE);
    assign bankOk    = 32'(wr_bank) < NUM_BANKS;
    assign isZeroReg = (wr_bank == BANK_W'(BANK_INT)) && (wr_addr == '0);
    assign pairLegal = (wr_bank != BANK_W'(BANK_INT)) && !wr_addr[0];
    assign hiAddr    = {wr_addr[ADDR_W-1:1], 1'b1};

    // Accepted halves; these also gate the bypass paths.
    always_comb begin
        loAcc   = 1'b0;
        hiAcc   = 1'b0;
        pairBad = 1'b0;
        if (wr_en && isIdle) begin
            if (wr_pair) begin
                pairBad = !pairLegal;
                loAcc   = pairLegal && bankOk;
                hiAcc   = pairLegal && bankOk;
            end else begin
                loAcc   = bankOk && !isZeroReg;
            end
        end
    end

    // Sweep FSM: one register per bank cleared per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLEAR;
            cnt      <= '0;
            busy     <= 1'b1;
            pair_err <= 1'b0;
        end else begin
            pair_err <= pairBad;
            unique case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    logic [NUM_RD*DATA_W-1:0] bankRd [NUM_BANKS];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic bankSel;
        assign bankSel = (wr_bank == BANK_W'(b));

        regfile_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_RD (NUM_RD)
        ) u_bank (
            .clk     (clk),
            .clrEn   (state == CLEAR),
            .clrAddr (cnt),
            .loEn    (loAcc && bankSel),
            .loAddr  (wr_addr),
            .loData  (wr_data),
            .hiEn    (hiAcc && bankSel),
            .hiAddr  (hiAddr),
            .hiData  (wr_data_hi),
            .rdAddr  (rd_addr),
            .rdData  (bankRd[b])
        );
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [BANK_W-1:0] pBank;
        logic [ADDR_W-1:0] pAddr;
        logic [DATA_W-1:0] pData;

        assign pBank = rd_bank[p*BANK_W +: BANK_W];
        assign pAddr = rd_addr[p*ADDR_W +: ADDR_W];

        // Priority: sweep/zero-reg force 0, then bypass, then storage.
        always_comb begin
            pData = '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (pBank == BANK_W'(b)) begin
                    pData = bankRd[b][p*DATA_W +: DATA_W];
                end
            end
            if (loAcc && pBank == wr_bank && pAddr == wr_addr) begin
                pData = wr_data;
            end
            if (hiAcc && pBank == wr_bank && pAddr == hiAddr) begin
                pData = wr_data_hi;
            end
            if (busy || (pBank == BANK_W'(BANK_INT) && pAddr == '0)) begin
                pData = '0;
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = pData;
    end

endmodule

// File: tb/tb_banked_register_file.sv
// Self-checking bench for banked_register_file: vector table,
// hand-written sweep/reset sequences and randomized model comparison.
module tb_banked_register_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NB = 2;
    localparam int NR = 2;
    localparam int BW = 1;
    localparam int DEPTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR*BW-1:0] rd_bank;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic             wr_en;
    logic [BW-1:0]    wr_bank;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             wr_pair;
    logic [DW-1:0]    wr_data_hi;
    logic             clr_req;
    logic             busy;
    logic             pair_err;

    banked_register_file dut (
        .clk        (clk),
        .rst        (rst),
        .rd_bank    (rd_bank),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_bank    (wr_bank),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_pair    (wr_pair),
        .wr_data_hi (wr_data_hi),
        .clr_req    (clr_req),
        .busy       (busy),
        .pair_err   (pair_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain register arrays plus remaining sweep cycles.
    logic [DW-1:0] mem [NB][DEPTH];
    int            mBusy;
    logic          expErr;

    task automatic cmp(string tag, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", tag, act, exp);
        end
    endtask

    task automatic clearMem();
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < DEPTH; a++)
                mem[b][a] = '0;
    endtask

    function automatic bit canWrite();
        return wr_en && !rst && mBusy == 0;
    endfunction

    function automatic bit legalPair();
        return wr_bank != 0 && !wr_addr[0];
    endfunction

    function automatic bit accLo();
        if (!canWrite() || int'(wr_bank) >= NB) return 0;
        if (wr_pair) return legalPair();
        return !(wr_bank == 0 && wr_addr == 0);
    endfunction

    function automatic bit accHi();
        return canWrite() && int'(wr_bank) < NB && wr_pair && legalPair();
    endfunction

    function automatic bit badPair();
        return canWrite() && wr_pair && !legalPair();
    endfunction

    function automatic logic [DW-1:0] expRead(int b, int a);
        if (mBusy > 0 || rst) return '0;
        if (b >= NB) return '0;
        if (b == 0 && a == 0) return '0;
        if (accLo() && int'(wr_bank) == b && int'(wr_addr) == a)
            return wr_data;
        if (accHi() && int'(wr_bank) == b && int'(wr_addr | 5'd1) == a)
            return wr_data_hi;
        return mem[b][a];
    endfunction

    task automatic tick();
        bit lo, hi, bad;
        int b, a;
        lo = accLo();
        hi = accHi();
        bad = badPair();
        b = int'(wr_bank);
        a = int'(wr_addr);
        @(posedge clk);
        if (rst) begin
            mBusy = DEPTH;
            expErr = 1'b0;
            clearMem();
        end else begin
            expErr = bad;
            if (lo) mem[b][a] = wr_data;
            if (hi) mem[b][a | 1] = wr_data_hi;
            if (mBusy > 0) mBusy--;
            else if (clr_req) begin
                mBusy = DEPTH;
                clearMem();
            end
        end
        #1;
    endtask

    task automatic checkAll(string tag);
        #1;
        for (int p = 0; p < NR; p++)
            cmp({tag, "_rd"}, rd_data[p*DW +: DW],
                expRead(int'(rd_bank[p]), int'(rd_addr[p*AW +: AW])));
        cmp({tag, "_busy"}, DW'(busy), DW'(mBusy > 0 || rst));
        cmp({tag, "_perr"}, DW'(pair_err), DW'(expErr));
    endtask

    task automatic idleIn();
        wr_en = 0; wr_bank = 0; wr_addr = 0; wr_data = 0;
        wr_pair = 0; wr_data_hi = 0; clr_req = 0;
    endtask

    task automatic setRd(int b0, int a0, int b1, int a1);
        rd_bank = {BW'(b1), BW'(b0)};
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    task automatic assertRst();
        rst = 1;
        mBusy = DEPTH;
        expErr = 0;
        clearMem();
    endtask

    // Counts busy cycles from now on, bounded; optional re-request at 10.
    task automatic countBusy(output int n, input bit reReq);
        n = 0;
        while (busy && n < 200) begin
            clr_req = reReq && n == 10;
            checkAll("sweep");
            tick();
            n++;
        end
        clr_req = 0;
    endtask

    typedef struct {
        bit        we;
        bit        wb;
        int        wa;
        logic [31:0] wd;
        bit        pr;
        logic [31:0] wdh;
        int        b0, a0, b1, a1;
        logic [31:0] e0, e1;
        bit        eErr;
    } vec_t;

    vec_t vt [15];

    initial begin
        int n;
        vt[0]  = '{1, 0, 1, 44,           0, 0,            0, 1, 1, 1, 44, 0, 0};
        vt[1]  = '{1, 1, 1, 32'h3F800000, 0, 0,            0, 1, 1, 1, 44, 32'h3F800000, 0};
        vt[2]  = '{0, 0, 0, 0,            0, 0,            0, 1, 1, 1, 44, 32'h3F800000, 0};
        vt[3]  = '{1, 0, 0, 7,            0, 0,            0, 0, 0, 0, 0, 0, 0};
        vt[4]  = '{0, 0, 0, 0,            0, 0,            0, 0, 1, 0, 0, 0, 0};
        vt[5]  = '{1, 0, 5, 9,            0, 0,            0, 5, 0, 5, 9, 9, 0};
        vt[6]  = '{1, 1, 4, 32'h11111111, 1, 32'h22222222, 1, 4, 1, 5, 32'h11111111, 32'h22222222, 0};
        vt[7]  = '{0, 0, 0, 0,            0, 0,            1, 4, 1, 5, 32'h11111111, 32'h22222222, 0};
        vt[8]  = '{1, 1, 7, 32'hAAAAAAAA, 1, 32'hBBBBBBBB, 1, 7, 1, 6, 0, 0, 1};
        vt[9]  = '{0, 0, 0, 0,            0, 0,            1, 7, 1, 8, 0, 0, 0};
        vt[10] = '{1, 0, 2, 5,            1, 6,            0, 2, 0, 3, 0, 0, 1};
        vt[11] = '{0, 0, 0, 0,            0, 0,            0, 2, 0, 3, 0, 0, 0};
        vt[12] = '{1, 1, 31, 32'hDEADBEEF, 0, 0,           1, 31, 0, 31, 32'hDEADBEEF, 0, 0};
        vt[13] = '{1, 0, 31, 32'h12345678, 0, 0,           1, 31, 0, 31, 32'hDEADBEEF, 32'h12345678, 0};
        vt[14] = '{0, 0, 0, 0,            0, 0,            0, 5, 0, 5, 9, 9, 0};

        idleIn();
        setRd(0, 0, 1, 0);
        assertRst();
        tick();
        tick();
        rst = 0;

        // Reset sweep with a write that must be dropped at sweep cycle 20.
        n = 0;
        while (busy && n < 200) begin
            wr_en = (n == 20);
            wr_bank = 0; wr_addr = 1; wr_data = 44;
            checkAll("rsweep");
            tick();
            n++;
        end
        idleIn();
        cmp("rst_busy_len", DW'(n), DW'(DEPTH));
        for (int a = 0; a < DEPTH; a++) begin
            setRd(0, a, 1, a);
            #1;
            cmp("rst_zero_b0", rd_data[0 +: DW], '0);
            cmp("rst_zero_b1", rd_data[DW +: DW], '0);
        end

        for (int i = 0; i < 15; i++) begin
            wr_en = vt[i].we; wr_bank = vt[i].wb; wr_addr = AW'(vt[i].wa);
            wr_data = vt[i].wd; wr_pair = vt[i].pr; wr_data_hi = vt[i].wdh;
            setRd(vt[i].b0, vt[i].a0, vt[i].b1, vt[i].a1);
            checkAll("vec");
            cmp($sformatf("vec%0d_p0", i), rd_data[0 +: DW], vt[i].e0);
            cmp($sformatf("vec%0d_p1", i), rd_data[DW +: DW], vt[i].e1);
            tick();
            cmp($sformatf("vec%0d_perr", i), DW'(pair_err), DW'(vt[i].eErr));
        end
        idleIn();

        // Clear request with an ignored second request mid-sweep.
        clr_req = 1;
        setRd(1, 4, 0, 5);
        checkAll("clr_req");
        tick();
        clr_req = 0;
        cmp("clr_busy_rise", DW'(busy), 1);
        countBusy(n, 1);
        cmp("clr_busy_len", DW'(n), DW'(DEPTH));
        for (int a = 0; a < DEPTH; a++) begin
            setRd(0, a, 1, a);
            #1;
            cmp("clr_zero_b0", rd_data[0 +: DW], '0);
            cmp("clr_zero_b1", rd_data[DW +: DW], '0);
        end

        // Async reset from idle, then reset again at sweep cycle 12.
        wr_en = 1; wr_bank = 1; wr_addr = 3; wr_data = 32'h55;
        tick();
        idleIn();
        assertRst();
        #1;
        cmp("rst_async_busy", DW'(busy), 1);
        tick();
        rst = 0;
        for (int i = 0; i < 12; i++) begin
            checkAll("pre_rst");
            tick();
        end
        assertRst();
        checkAll("mid_rst");
        tick();
        rst = 0;
        countBusy(n, 0);
        cmp("midrst_busy_len", DW'(n), DW'(DEPTH));

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            wr_en = $urandom_range(0, 3) != 0;
            wr_bank = BW'($urandom);
            wr_addr = AW'($urandom_range(0, 7) == 0 ? 0 : $urandom);
            wr_data = $urandom;
            wr_pair = $urandom_range(0, 3) == 0;
            wr_data_hi = $urandom;
            clr_req = $urandom_range(0, 99) == 0;
            if ($urandom_range(0, 2) == 0)
                setRd(int'(wr_bank), int'(wr_addr | AW'($urandom_range(0, 1))),
                      int'(wr_bank), int'(wr_addr));
            else
                setRd($urandom_range(0, 1), $urandom_range(0, 31),
                      $urandom_range(0, 1), $urandom_range(0, 31));
            checkAll("rand");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
